led_bank_arbiter: RTL and testbench

- Shares the 8 active-low board LEDs between NREQ requesters (heartbeat counter, status display, error flash, etc.).
- Fixed-priority arbitration with a minimum ownership hold time and a blank gap between owners.
- Per-owner 3-bit PWM brightness; drives the registered LED pins.
- Sits between the design's LED pattern sources and the top-level led[7:0] output.

---
 rtl/led_arb_pkg.sv | 24 ++
 rtl/led_pwm_out.sv | 62 ++++++
 rtl/led_bank_arbiter.sv | 161 ++++++++++++++++
 tb/tb_led_bank_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_arb_pkg.sv
// Shared types and constants for the LED bank arbiter.
package led_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOwn,
    StBlank
  } arb_state_e;

  localparam logic [7:0]  LED_OFF  = 8'hFF;
  localparam int unsigned PWM_BITS = 3;
  localparam int unsigned OWNER_W  = 3;

  // Index of the lowest set bit (highest priority); 0 when nothing is set.
  function automatic logic [OWNER_W-1:0] prio_enc(input logic [7:0] vec);
    logic [OWNER_W-1:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (vec[i]) idx = OWNER_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/led_pwm_out.sv
// PWM brightness generator and registered active-low LED pin driver.
module led_pwm_out
  import led_arb_pkg::*;
#(
  parameter int unsigned USEIOFF = 1
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_active,
  input  logic [7:0]          i_pattern,
  input  logic [PWM_BITS-1:0] i_bright,
  output logic [7:0]          o_led
);

  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic                w_duty;
  logic [7:0]          w_led_d;

  // Free-running PWM phase counter; wraps 7 -> 0 on its own.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pwm_cnt <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
    end
  end

  // Duty compare and pin value; bright 0 still lights one slot in eight.
  always_comb begin
    w_duty  = (r_pwm_cnt <= i_bright);
    w_led_d = i_active ? ~(i_pattern & {8{w_duty}}) : LED_OFF;
  end

  if (USEIOFF != 0) begin : gen_ioff
    (* syn_useioff = 1 *) logic [7:0] r_led;

    // Pin register packed into the I/O cell.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_led <= LED_OFF;
      end else begin
        r_led <= w_led_d;
      end
    end

    assign o_led = r_led;
  end else begin : gen_fabric
    (* syn_useioff = 0 *) logic [7:0] r_led;

    // Pin register kept in fabric.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_led <= LED_OFF;
      end else begin
        r_led <= w_led_d;
      end
    end

    assign o_led = r_led;
  end

endmodule

// File: rtl/led_bank_arbiter.sv
// Fixed-priority owner arbitration for the shared board LEDs, with a minimum
// hold before preemption and a dark gap between successive owners.
module led_bank_arbiter
  import led_arb_pkg::*;
#(
  parameter int unsigned NREQ         = 4,
  parameter int unsigned HOLD_CYCLES  = 3000000,
  parameter int unsigned BLANK_CYCLES = 12000,
  parameter int unsigned USEIOFF      = 1
) (
  input  logic                 clk_12mhz,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [8*NREQ-1:0]    req_pattern,
  input  logic [3*NREQ-1:0]    req_bright,
  output logic [NREQ-1:0]      gnt,
  output logic [OWNER_W-1:0]   owner,
  output logic                 busy,
  output logic [7:0]           led
);

  if (NREQ < 2 || NREQ > 8) begin : gen_bad_nreq
    $error("led_bank_arbiter: NREQ must be in 2..8");
  end
  if (HOLD_CYCLES < 1) begin : gen_bad_hold
    $error("led_bank_arbiter: HOLD_CYCLES must be >= 1");
  end
  if (BLANK_CYCLES < 1) begin : gen_bad_blank
    $error("led_bank_arbiter: BLANK_CYCLES must be >= 1");
  end

  localparam int unsigned HoldW  = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned BlankW = $clog2(BLANK_CYCLES + 1);
  localparam logic [HoldW-1:0]  HoldLoad  = HoldW'(HOLD_CYCLES - 1);
  localparam logic [BlankW-1:0] BlankLoad = BlankW'(BLANK_CYCLES - 1);

  arb_state_e          r_state, w_state_d;
  logic [HoldW-1:0]    r_hold;
  logic [BlankW-1:0]   r_blank;
  logic [NREQ-1:0]     r_gnt, w_gnt_d;
  logic [OWNER_W-1:0]  r_owner, w_owner_d;
  logic                r_busy, w_busy_d;

  logic [7:0]          w_req8;
  logic                w_any_req;
  logic                w_owner_req;
  logic                w_higher_req;
  logic                w_enter_own;
  logic                w_enter_blank;
  logic [7:0]          w_pat;
  logic [PWM_BITS-1:0] w_bright;

  // Decode requests relative to the current owner and pick its live pattern.
  always_comb begin
    w_req8       = '0;
    w_owner_req  = 1'b0;
    w_higher_req = 1'b0;
    w_pat        = '0;
    w_bright     = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_req8[i] = req[i];
      if (r_owner == OWNER_W'(i)) begin
        w_owner_req = req[i];
        w_pat       = req_pattern[8*i +: 8];
        w_bright    = req_bright[3*i +: 3];
      end
      if (OWNER_W'(i) < r_owner) begin
        w_higher_req = w_higher_req | req[i];
      end
    end
    w_any_req = |req;
  end

  // FSM state register.
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state: release always wins; preemption only once the hold expires.
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_any_req) w_state_d = StOwn;
      end
      StOwn: begin
        if (!w_owner_req || (r_hold == '0 && w_higher_req)) w_state_d = StBlank;
      end
      StBlank: begin
        if (r_blank == '0) w_state_d = w_any_req ? StOwn : StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  assign w_enter_own   = (w_state_d == StOwn) && (r_state != StOwn);
  assign w_enter_blank = (w_state_d == StBlank) && (r_state != StBlank);

  // Hold and blank down-counters, loaded on state entry, saturating at zero.
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_hold  <= '0;
      r_blank <= '0;
    end else begin
      if (w_enter_own) begin
        r_hold <= HoldLoad;
      end else if (r_state == StOwn && r_hold != '0) begin
        r_hold <= r_hold - HoldW'(1);
      end
      if (w_enter_blank) begin
        r_blank <= BlankLoad;
      end else if (r_state == StBlank && r_blank != '0) begin
        r_blank <= r_blank - BlankW'(1);
      end
    end
  end

  // Output decode from the next state so gnt/owner/busy come straight off flops.
  always_comb begin
    w_owner_d = r_owner;
    if (w_enter_own) w_owner_d = prio_enc(w_req8);
    w_busy_d = (w_state_d == StOwn);
    w_gnt_d  = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_gnt_d[i] = w_busy_d && (w_owner_d == OWNER_W'(i));
    end
  end

  // Registered grant outputs; owner holds its last value outside OWN.
  always_ff @(posedge clk_12mhz or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt   <= '0;
      r_owner <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_gnt   <= w_gnt_d;
      r_owner <= w_owner_d;
      r_busy  <= w_busy_d;
    end
  end

  led_pwm_out #(
    .USEIOFF (USEIOFF)
  ) u_pwm_out (
    .i_clk     (clk_12mhz),
    .i_rst_n   (rst_n),
    .i_active  (r_busy),
    .i_pattern (w_pat),
    .i_bright  (w_bright),
    .o_led     (led)
  );

  assign gnt   = r_gnt;
  assign owner = r_owner;
  assign busy  = r_busy;

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Scenario bench for led_bank_arbiter with short hold/blank times.
module tb_led_bank_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_pattern;
  logic [11:0] req_bright;
  logic [3:0]  gnt;
  logic [2:0]  owner;
  logic        busy;
  logic [7:0]  led;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic       busy;
    logic [2:0] owner;
    logic [7:0] led;
    logic       chk_led;
  } exp_t;

  exp_t exp_q[$];
  int   cnt_q[$];

  led_bank_arbiter #(
    .NREQ         (4),
    .HOLD_CYCLES  (8),
    .BLANK_CYCLES (4),
    .USEIOFF      (1)
  ) dut (
    .clk_12mhz   (clk),
    .rst_n       (rst_n),
    .req         (req),
    .req_pattern (req_pattern),
    .req_bright  (req_bright),
    .gnt         (gnt),
    .owner       (owner),
    .busy        (busy),
    .led         (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void push(input string tag, input logic [3:0] g, input logic [2:0] o,
                               input logic [7:0] l, input logic cl);
    exp_t e;
    e.tag     = tag;
    e.gnt     = g;
    e.busy    = |g;
    e.owner   = o;
    e.led     = l;
    e.chk_led = cl;
    exp_q.push_back(e);
  endfunction

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    push("por", 4'b0000, 3'd0, 8'hFF, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    e = exp_q.pop_front();
    checks++;
    if (gnt !== e.gnt || busy !== e.busy || owner !== e.owner || led !== e.led) begin
      errors++;
      $display("FAIL %s: got gnt=%b busy=%b owner=%0d led=%h, want gnt=%b busy=%b owner=%0d led=%h",
               e.tag, gnt, busy, owner, led, e.gnt, e.busy, e.owner, e.led);
    end
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 1; c <= 3; c++) begin
      if (c == 1) begin
        req = 4'b1000;
        req_pattern[31:24] = 8'h81;
        req_bright[11:9] = 3'd7;
      end
      push("own3", 4'b1000, 3'd3, (c == 1) ? 8'hFF : 8'h7E, 1'b1);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.gnt || busy !== e.busy || owner !== e.owner || led !== e.led) begin
        errors++;
        $display("FAIL %s c=%0d: got gnt=%b busy=%b owner=%0d led=%h, want gnt=%b busy=%b owner=%0d led=%h",
                 e.tag, c, gnt, busy, owner, led, e.gnt, e.busy, e.owner, e.led);
      end
    end
    // Mid-cycle assertion must clear outputs without waiting for a clock edge.
    #3 rst_n = 1'b0;
    #1;
    push("async_rst", 4'b0000, 3'd0, 8'hFF, 1'b1);
    e = exp_q.pop_front();
    checks++;
    if (gnt !== e.gnt || busy !== e.busy || owner !== e.owner || led !== e.led) begin
      errors++;
      $display("FAIL %s: got gnt=%b busy=%b owner=%0d led=%h, want gnt=%b busy=%b owner=%0d led=%h",
               e.tag, gnt, busy, owner, led, e.gnt, e.busy, e.owner, e.led);
    end
    @(posedge clk);
    #1 req = 4'b0000;
    @(negedge clk) rst_n = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      push("post_rst", 4'b0000, 3'd0, 8'hFF, 1'b1);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.gnt || busy !== e.busy || owner !== e.owner || led !== e.led) begin
        errors++;
        $display("FAIL %s c=%0d: got gnt=%b busy=%b owner=%0d led=%h, want gnt=%b busy=%b owner=%0d led=%h",
                 e.tag, c, gnt, busy, owner, led, e.gnt, e.busy, e.owner, e.led);
      end
    end
  endtask

  task automatic test_grant();
    exp_t e;
    for (int c = 1; c <= 12; c++) begin
      if (c == 1) begin
        req = 4'b0100;
        req_pattern[23:16] = 8'hA5;
        req_bright[8:6] = 3'd7;
      end
      if (c == 7) req = 4'b0000;
      if (c == 1)      push("grant", 4'b0100, 3'd2, 8'hFF, 1'b1);
      else if (c <= 6) push("grant", 4'b0100, 3'd2, 8'h5A, 1'b1);
      else if (c == 7) push("release", 4'b0000, 3'd2, 8'h5A, 1'b1);
      else             push("release", 4'b0000, 3'd2, 8'hFF, 1'b1);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.gnt || busy !== e.busy || owner !== e.owner
          || (e.chk_led && led !== e.led)) begin
        errors++;
        $display("FAIL %s c=%0d: got gnt=%b busy=%b owner=%0d led=%h, want gnt=%b busy=%b owner=%0d led=%h",
                 e.tag, c, gnt, busy, owner, led, e.gnt, e.busy, e.owner, e.led);
      end
    end
  endtask

  task automatic test_preempt();
    exp_t       e;
    logic [3:0] g;
    logic [7:0] l;
    for (int c = 1; c <= 21; c++) begin
      if (c == 1) begin
        req = 4'b0100;
        req_pattern[23:16] = 8'hA5;
        req_bright[8:6] = 3'd7;
        req_pattern[7:0] = 8'h3C;
        req_bright[2:0] = 3'd7;
      end
      if (c == 4)  req = 4'b0101;
      if (c == 16) req = 4'b0000;
      g = (c <= 8) ? 4'b0100 : (c <= 12) ? 4'b0000 : (c <= 15) ? 4'b0001 : 4'b0000;
      l = (c == 1) ? 8'hFF : (c <= 9) ? 8'h5A : (c <= 13) ? 8'hFF : (c <= 16) ? 8'hC3 : 8'hFF;
      push("preempt", g, (c <= 12) ? 3'd2 : 3'd0, l, 1'b1);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.gnt || busy !== e.busy || owner !== e.owner
          || (e.chk_led && led !== e.led)) begin
        errors++;
        $display("FAIL %s c=%0d: got gnt=%b busy=%b owner=%0d led=%h, want gnt=%b busy=%b owner=%0d led=%h",
                 e.tag, c, gnt, busy, owner, led, e.gnt, e.busy, e.owner, e.led);
      end
    end
  endtask

  task automatic test_low_no_preempt();
    exp_t       e;
    logic [3:0] g;
    logic [7:0] l;
    for (int c = 1; c <= 28; c++) begin
      if (c == 1) begin
        req = 4'b0010;
        req_pattern[15:8] = 8'h0F;
        req_bright[5:3] = 3'd7;
        req_pattern[31:24] = 8'hC0;
        req_bright[11:9] = 3'd7;
      end
      if (c == 3)  req = 4'b1010;
      if (c == 16) req = 4'b1000;
      if (c == 23) req = 4'b0000;
      g = (c <= 15) ? 4'b0010 : (c <= 19) ? 4'b0000 : (c <= 22) ? 4'b1000 : 4'b0000;
      l = (c == 1) ? 8'hFF : (c <= 16) ? 8'hF0 : (c <= 20) ? 8'hFF : (c <= 23) ? 8'h3F : 8'hFF;
      push("low_req", g, (c <= 19) ? 3'd1 : 3'd3, l, 1'b1);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.gnt || busy !== e.busy || owner !== e.owner
          || (e.chk_led && led !== e.led)) begin
        errors++;
        $display("FAIL %s c=%0d: got gnt=%b busy=%b owner=%0d led=%h, want gnt=%b busy=%b owner=%0d led=%h",
                 e.tag, c, gnt, busy, owner, led, e.gnt, e.busy, e.owner, e.led);
      end
    end
  endtask

  task automatic test_pwm();
    exp_t e;
    int   lows;
    int   want;
    lows = 0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 1) begin
        req = 4'b0001;
        req_pattern[7:0] = 8'hFF;
        req_bright[2:0] = 3'd0;
      end
      if (c == 11) req_bright[2:0] = 3'd3;
      if (c == 19) req = 4'b0000;
      if (c == 3 || c == 11) begin
        cnt_q.push_back((c == 3) ? 1 : 4);
        lows = 0;
      end
      push("pwm", (c <= 18) ? 4'b0001 : 4'b0000, 3'd0, 8'hFF, (c == 1 || c >= 20));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.gnt || busy !== e.busy || owner !== e.owner
          || (e.chk_led && led !== e.led)) begin
        errors++;
        $display("FAIL %s c=%0d: got gnt=%b busy=%b owner=%0d led=%h, want gnt=%b busy=%b owner=%0d led=%h",
                 e.tag, c, gnt, busy, owner, led, e.gnt, e.busy, e.owner, e.led);
      end
      if (c >= 3 && c <= 18) begin
        if (led === 8'h00) lows++;
        else if (led !== 8'hFF) lows += 100;
      end
      if (c == 10 || c == 18) begin
        want = cnt_q.pop_front();
        checks++;
        if (lows != want) begin
          errors++;
          $display("FAIL pwm_duty c=%0d: got %0d lit slots of 8, want %0d", c, lows, want);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t       e;
    logic [3:0] g;
    logic [7:0] l;
    for (int c = 1; c <= 22; c++) begin
      if (c == 1) begin
        req = 4'b0100;
        req_pattern[23:16] = 8'hA5;
        req_bright[8:6] = 3'd7;
        req_pattern[7:0] = 8'h3C;
        req_bright[2:0] = 3'd7;
      end
      if (c == 10) req = 4'b0001;
      if (c == 17) req = 4'b0000;
      g = (c <= 9) ? 4'b0100 : (c <= 13) ? 4'b0000 : (c <= 16) ? 4'b0001 : 4'b0000;
      l = (c == 1) ? 8'hFF : (c <= 10) ? 8'h5A : (c <= 14) ? 8'hFF : (c <= 17) ? 8'hC3 : 8'hFF;
      push("handover", g, (c <= 13) ? 3'd2 : 3'd0, l, 1'b1);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if (gnt !== e.gnt || busy !== e.busy || owner !== e.owner
          || (e.chk_led && led !== e.led)) begin
        errors++;
        $display("FAIL %s c=%0d: got gnt=%b busy=%b owner=%0d led=%h, want gnt=%b busy=%b owner=%0d led=%h",
                 e.tag, c, gnt, busy, owner, led, e.gnt, e.busy, e.owner, e.led);
      end
      checks++;
      if (!$onehot0(gnt)) begin
        errors++;
        $display("FAIL gnt_onehot c=%0d: got gnt=%b, want at most one bit set", c, gnt);
      end
    end
  endtask

  initial begin
    rst_n       = 1'b1;
    req         = '0;
    req_pattern = '0;
    req_bright  = '0;
    test_reset();
    test_grant();
    test_preempt();
    test_low_no_preempt();
    test_pwm();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
